// File: rtl/rlwe_arb_pkg.sv
// -----------------------------------------------------------------------------
// rlwe_arb_pkg
// Types and constants for the two-port DMEM arbiter: FSM state encoding,
// port identifier and the default response timeout.
// -----------------------------------------------------------------------------
package rlwe_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_BUSY  = 2'b01,
        ARB_DRAIN = 2'b10
    } type_rlwe_arb_fsm_e;

    typedef enum logic {
        ARB_PORT0 = 1'b0,
        ARB_PORT1 = 1'b1
    } type_rlwe_arb_port_e;

    localparam int unsigned RLWE_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/scr1_memif_pkg.sv
// -----------------------------------------------------------------------------
// scr1_memif_pkg
// Memory-interface types shared by the core LSU, the RLWE vector engine and
// the data memory: command, access width, response code and the vector data
// word carried on the data buses. Also provides the DMEM address width macro.
// -----------------------------------------------------------------------------
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Vector data word: four 32-bit lanes, lane 0 in the low bits.
    localparam int unsigned SCR1_VEC_LANES = 4;
    typedef logic [SCR1_VEC_LANES-1:0][31:0] type_vector;

endpackage

// File: rtl/rlwe_dmem_arb.sv
// -----------------------------------------------------------------------------
// rlwe_dmem_arb
// Round-robin arbiter sharing one DMEM port between the core LSU (port 0) and
// the RLWE vector engine (port 1). At most one transaction is outstanding.
// A response that does not arrive within TIMEOUT_CYCLES is answered locally
// with RDY_ER and the late memory response is swallowed in DRAIN.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   p0_* / p1_*  (req side)     requester command, width, address, write data
//   p0_* / p1_*  (resp side)    req_ack, rdata, resp back to each requester
//   mem_*                       shared DMEM request / handshake / response
//   arb_busy_o                  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

module rlwe_dmem_arb
    import scr1_memif_pkg::*;
    import rlwe_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = RLWE_ARB_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          p0_req_i,
    input  type_scr1_mem_cmd_e            p0_cmd_i,
    input  type_scr1_mem_width_e          p0_width_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  p0_addr_i,
    input  type_vector                    p0_wdata_i,
    output logic                          p0_req_ack_o,
    output type_vector                    p0_rdata_o,
    output type_scr1_mem_resp_e           p0_resp_o,
    input  logic                          p1_req_i,
    input  type_scr1_mem_cmd_e            p1_cmd_i,
    input  type_scr1_mem_width_e          p1_width_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  p1_addr_i,
    input  type_vector                    p1_wdata_i,
    output logic                          p1_req_ack_o,
    output type_vector                    p1_rdata_o,
    output type_scr1_mem_resp_e           p1_resp_o,
    output logic                          mem_req_o,
    output type_scr1_mem_cmd_e            mem_cmd_o,
    output type_scr1_mem_width_e          mem_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0]  mem_addr_o,
    output type_vector                    mem_wdata_o,
    input  logic                          mem_req_ack_i,
    input  type_vector                    mem_rdata_i,
    input  type_scr1_mem_resp_e           mem_resp_i,
    output logic                          arb_busy_o
);

    localparam logic [7:0] TIMEOUT_VAL  = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    type_rlwe_arb_fsm_e   state_q;
    type_rlwe_arb_port_e  last_grant_q;
    type_rlwe_arb_port_e  owner_q;
    logic [7:0]           timer_q;

    type_rlwe_arb_port_e  grant_s;
    logic                 sel_req_s;
    logic                 resp_valid_s;
    logic                 timeout_s;
    type_scr1_mem_resp_e  owner_resp_s;
    type_vector           owner_rdata_s;

    // Grant selection: a lone requester wins, contention goes to the port that did not win last.
    always_comb begin
        grant_s = ARB_PORT0;
        if (p0_req_i && p1_req_i) begin
            grant_s = (last_grant_q == ARB_PORT0) ? ARB_PORT1 : ARB_PORT0;
        end else if (p1_req_i) begin
            grant_s = ARB_PORT1;
        end else begin
            grant_s = ARB_PORT0;
        end
    end

    assign sel_req_s    = (grant_s == ARB_PORT1) ? p1_req_i : p0_req_i;
    assign resp_valid_s = (mem_resp_i == SCR1_MEM_RESP_RDY_OK) ||
                          (mem_resp_i == SCR1_MEM_RESP_RDY_ER);
    // A real response in the deadline cycle takes precedence over the timeout.
    assign timeout_s    = (state_q == ARB_BUSY) && !resp_valid_s && (timer_q == TIMEOUT_LAST);
    assign arb_busy_o   = (state_q != ARB_IDLE);

    // Response seen by the owner: pass-through, or a local error on timeout.
    always_comb begin
        owner_resp_s  = mem_resp_i;
        owner_rdata_s = mem_rdata_i;
        if (timeout_s) begin
            owner_resp_s  = SCR1_MEM_RESP_RDY_ER;
            owner_rdata_s = '0;
        end else begin
            owner_resp_s  = mem_resp_i;
            owner_rdata_s = mem_rdata_i;
        end
    end

    // Output steering for the shared request and both requester responses.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_cmd_o    = p0_cmd_i;
        mem_width_o  = p0_width_i;
        mem_addr_o   = p0_addr_i;
        mem_wdata_o  = p0_wdata_i;
        p0_req_ack_o = 1'b0;
        p1_req_ack_o = 1'b0;
        p0_resp_o    = SCR1_MEM_RESP_NOTRDY;
        p1_resp_o    = SCR1_MEM_RESP_NOTRDY;
        p0_rdata_o   = '0;
        p1_rdata_o   = '0;
        if (grant_s == ARB_PORT1) begin
            mem_cmd_o   = p1_cmd_i;
            mem_width_o = p1_width_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end else begin
            mem_cmd_o   = p0_cmd_i;
            mem_width_o = p0_width_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end
        case (state_q)
            ARB_IDLE: begin
                // Handshake outputs are held low while reset is asserted.
                if (rst_n) begin
                    mem_req_o    = sel_req_s;
                    p0_req_ack_o = mem_req_ack_i && (grant_s == ARB_PORT0);
                    p1_req_ack_o = mem_req_ack_i && (grant_s == ARB_PORT1);
                end else begin
                    mem_req_o    = 1'b0;
                    p0_req_ack_o = 1'b0;
                    p1_req_ack_o = 1'b0;
                end
            end
            ARB_BUSY: begin
                if (owner_q == ARB_PORT1) begin
                    p1_resp_o  = owner_resp_s;
                    p1_rdata_o = owner_rdata_s;
                end else begin
                    p0_resp_o  = owner_resp_s;
                    p0_rdata_o = owner_rdata_s;
                end
            end
            ARB_DRAIN: begin
                mem_req_o = 1'b0;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Arbiter FSM with ownership, round-robin history and response timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_PORT1;
            owner_q      <= ARB_PORT0;
            timer_q      <= 8'd0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (sel_req_s && mem_req_ack_i) begin
                        state_q      <= ARB_BUSY;
                        owner_q      <= grant_s;
                        last_grant_q <= grant_s;
                        timer_q      <= 8'd0;
                    end
                end
                ARB_BUSY: begin
                    if (resp_valid_s) begin
                        state_q <= ARB_IDLE;
                    end else if (timeout_s) begin
                        state_q <= ARB_DRAIN;
                    end else if (timer_q != TIMEOUT_VAL) begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ARB_DRAIN: begin
                    // Only the late response releases DRAIN.
                    if (resp_valid_s) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rlwe_dmem_arb.sv
module tb_rlwe_dmem_arb;
    import scr1_memif_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst_n = 1'b1;
    logic                         p0_req, p1_req, mem_req_ack;
    type_scr1_mem_cmd_e           p0_cmd, p1_cmd;
    type_scr1_mem_width_e         p0_width, p1_width;
    logic [`SCR1_DMEM_AWIDTH-1:0] p0_addr, p1_addr;
    type_vector                   p0_wdata, p1_wdata, mem_rdata;
    type_scr1_mem_resp_e          mem_resp;

    logic                         p0_req_ack, p1_req_ack, mem_req, arb_busy;
    type_vector                   p0_rdata, p1_rdata, mem_wdata;
    type_scr1_mem_resp_e          p0_resp, p1_resp;
    type_scr1_mem_cmd_e           mem_cmd;
    type_scr1_mem_width_e         mem_width;
    logic [`SCR1_DMEM_AWIDTH-1:0] mem_addr;

    logic                         p0_req_ack_4, p1_req_ack_4, mem_req_4, arb_busy_4;
    type_vector                   p0_rdata_4, p1_rdata_4, mem_wdata_4;
    type_scr1_mem_resp_e          p0_resp_4, p1_resp_4;
    type_scr1_mem_cmd_e           mem_cmd_4;
    type_scr1_mem_width_e         mem_width_4;
    logic [`SCR1_DMEM_AWIDTH-1:0] mem_addr_4;

    int checks = 0;
    int errors = 0;
    type_vector exp_vec;
    type_vector zero_vec;

    rlwe_dmem_arb u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req), .p0_cmd_i(p0_cmd), .p0_width_i(p0_width), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_req_ack_o(p0_req_ack), .p0_rdata_o(p0_rdata), .p0_resp_o(p0_resp),
        .p1_req_i(p1_req), .p1_cmd_i(p1_cmd), .p1_width_i(p1_width), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_req_ack_o(p1_req_ack), .p1_rdata_o(p1_rdata), .p1_resp_o(p1_resp),
        .mem_req_o(mem_req), .mem_cmd_o(mem_cmd), .mem_width_o(mem_width), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_req_ack_i(mem_req_ack), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp),
        .arb_busy_o(arb_busy)
    );

    rlwe_dmem_arb #(.TIMEOUT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req), .p0_cmd_i(p0_cmd), .p0_width_i(p0_width), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_req_ack_o(p0_req_ack_4), .p0_rdata_o(p0_rdata_4), .p0_resp_o(p0_resp_4),
        .p1_req_i(p1_req), .p1_cmd_i(p1_cmd), .p1_width_i(p1_width), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_req_ack_o(p1_req_ack_4), .p1_rdata_o(p1_rdata_4), .p1_resp_o(p1_resp_4),
        .mem_req_o(mem_req_4), .mem_cmd_o(mem_cmd_4), .mem_width_o(mem_width_4), .mem_addr_o(mem_addr_4), .mem_wdata_o(mem_wdata_4),
        .mem_req_ack_i(mem_req_ack), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp),
        .arb_busy_o(arb_busy_4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p1_req = 1'b0; mem_req_ack = 1'b0;
        p0_cmd = SCR1_MEM_CMD_RD; p1_cmd = SCR1_MEM_CMD_RD;
        p0_width = SCR1_MEM_WIDTH_WORD; p1_width = SCR1_MEM_WIDTH_WORD;
        p0_addr = 32'h0000_0100; p1_addr = 32'h0000_0200;
        p0_wdata = '0; p1_wdata = '0; mem_rdata = '0;
        mem_resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        rst_n = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1; mem_req_ack = 1'b1;
        mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata[0] = 32'hA5A5_A5A5;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0h expected 0", mem_req); end
        checks++; if (p0_req_ack !== 1'b0) begin errors++; $display("FAIL rst_p0_ack: got %0h expected 0", p0_req_ack); end
        checks++; if (p1_req_ack !== 1'b0) begin errors++; $display("FAIL rst_p1_ack: got %0h expected 0", p1_req_ack); end
        checks++; if (p0_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rst_p0_resp: got %0h expected 0", p0_resp); end
        checks++; if (p1_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rst_p1_resp: got %0h expected 0", p1_resp); end
        checks++; if (p0_rdata !== zero_vec) begin errors++; $display("FAIL rst_p0_rdata: got %0h expected 0", p0_rdata); end
        checks++; if (p1_rdata !== zero_vec) begin errors++; $display("FAIL rst_p1_rdata: got %0h expected 0", p1_rdata); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", arb_busy); end
        idle_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        p0_req = 1'b1; p0_cmd = SCR1_MEM_CMD_RD; p0_width = SCR1_MEM_WIDTH_WORD; p0_addr = 32'h0000_0100;
        mem_req_ack = 1'b1;
        #2;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_mem_req: got %0h expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rd_mem_addr: got %0h expected 100", mem_addr); end
        checks++; if (mem_cmd !== SCR1_MEM_CMD_RD) begin errors++; $display("FAIL rd_mem_cmd: got %0h expected 0", mem_cmd); end
        checks++; if (p0_req_ack !== 1'b1) begin errors++; $display("FAIL rd_p0_ack: got %0h expected 1", p0_req_ack); end
        checks++; if (p1_req_ack !== 1'b0) begin errors++; $display("FAIL rd_p1_ack: got %0h expected 0", p1_req_ack); end
        step();
        p0_req = 1'b0; mem_req_ack = 1'b0;
        #2;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c1: got %0h expected 1", arb_busy); end
        checks++; if (p0_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rd_p0_resp_c1: got %0h expected 0", p0_resp); end
        step();
        mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = '0; mem_rdata[0] = 32'hDEAD_BEEF;
        exp_vec = '0; exp_vec[0] = 32'hDEAD_BEEF;
        #2;
        checks++; if (p0_resp !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL rd_p0_resp_c2: got %0h expected 1", p0_resp); end
        checks++; if (p0_rdata !== exp_vec) begin errors++; $display("FAIL rd_p0_rdata: got %0h expected %0h", p0_rdata, exp_vec); end
        checks++; if (p1_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rd_p1_resp: got %0h expected 0", p1_resp); end
        checks++; if (p1_rdata !== zero_vec) begin errors++; $display("FAIL rd_p1_rdata: got %0h expected 0", p1_rdata); end
        step();
        mem_resp = SCR1_MEM_RESP_NOTRDY; mem_rdata = '0;
        #2;
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_c3: got %0h expected 0", arb_busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] got_own;
        logic [1:0] got_oth;
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1; mem_req_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_resp = SCR1_MEM_RESP_NOTRDY;
            #2;
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rr_mem_req[%0d]: got %0h expected 1", i, mem_req); end
            checks++; if (mem_addr !== ((i % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100)) begin errors++; $display("FAIL rr_addr[%0d]: got %0h expected port %0d", i, mem_addr, i % 2); end
            checks++; if ({p1_req_ack, p0_req_ack} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_acks[%0d]: got %0b expected port %0d", i, {p1_req_ack, p0_req_ack}, i % 2); end
            step();
            mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata[0] = 32'h0000_1000 + i;
            #2;
            got_own = (i % 2 == 1) ? p1_resp : p0_resp;
            got_oth = (i % 2 == 1) ? p0_resp : p1_resp;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rr_busy_req[%0d]: got %0h expected 0", i, mem_req); end
            checks++; if (got_own !== 2'b01) begin errors++; $display("FAIL rr_owner_resp[%0d]: got %0h expected 1", i, got_own); end
            checks++; if (got_oth !== 2'b00) begin errors++; $display("FAIL rr_other_resp[%0d]: got %0h expected 0", i, got_oth); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        p1_req = 1'b1; p1_cmd = SCR1_MEM_CMD_WR; p1_addr = 32'h0000_0300;
        p1_wdata = '0; p1_wdata[1] = 32'h1357_9BDF;
        exp_vec = '0; exp_vec[1] = 32'h1357_9BDF;
        mem_req_ack = 1'b1;
        #2;
        checks++; if (p1_req_ack !== 1'b1) begin errors++; $display("FAIL to_p1_ack: got %0h expected 1", p1_req_ack); end
        checks++; if (mem_cmd !== SCR1_MEM_CMD_WR) begin errors++; $display("FAIL to_mem_cmd: got %0h expected 1", mem_cmd); end
        checks++; if (mem_wdata !== exp_vec) begin errors++; $display("FAIL to_mem_wdata: got %0h expected %0h", mem_wdata, exp_vec); end
        step();
        p1_req = 1'b0; mem_req_ack = 1'b0; mem_rdata[0] = 32'hCAFE_F00D;
        bad = 0;
        for (int k = 0; k < 254; k++) begin
            #2;
            if (p1_resp !== SCR1_MEM_RESP_NOTRDY || arb_busy !== 1'b1) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_wait_cycles: got %0d bad cycles expected 0", bad); end
        #2;
        checks++; if (p1_resp !== SCR1_MEM_RESP_RDY_ER) begin errors++; $display("FAIL to_p1_err: got %0h expected 2", p1_resp); end
        checks++; if (p1_rdata !== zero_vec) begin errors++; $display("FAIL to_p1_rdata: got %0h expected 0", p1_rdata); end
        checks++; if (p0_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL to_p0_resp: got %0h expected 0", p0_resp); end
        step();
        p0_req = 1'b1; mem_req_ack = 1'b1;
        #2;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %0h expected 1", arb_busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_mem_req: got %0h expected 0", mem_req); end
        checks++; if (p0_req_ack !== 1'b0) begin errors++; $display("FAIL drain_p0_ack: got %0h expected 0", p0_req_ack); end
        step();
        #2;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL drain_hold: got %0h expected 1", arb_busy); end
        step();
        mem_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        checks++; if (p1_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL drain_swallow_resp: got %0h expected 0", p1_resp); end
        checks++; if (p1_rdata !== zero_vec) begin errors++; $display("FAIL drain_swallow_rdata: got %0h expected 0", p1_rdata); end
        step();
        mem_resp = SCR1_MEM_RESP_NOTRDY; mem_req_ack = 1'b0;
        #2;
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL drain_exit: got %0h expected 0", arb_busy); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drain_next_req: got %0h expected 1", mem_req); end
        idle_inputs();
    endtask

    task automatic test_pending();
        do_reset();
        p1_req = 1'b1; mem_req_ack = 1'b1;
        #2;
        checks++; if (p1_req_ack !== 1'b1) begin errors++; $display("FAIL pend_p1_ack: got %0h expected 1", p1_req_ack); end
        step();
        p1_req = 1'b0; p0_req = 1'b1; p0_addr = 32'h0000_0140;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pend_mem_req[%0d]: got %0h expected 0", k, mem_req); end
            checks++; if (p0_req_ack !== 1'b0) begin errors++; $display("FAIL pend_p0_ack[%0d]: got %0h expected 0", k, p0_req_ack); end
            step();
        end
        mem_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pend_resp_req: got %0h expected 0", mem_req); end
        checks++; if (p0_req_ack !== 1'b0) begin errors++; $display("FAIL pend_resp_ack: got %0h expected 0", p0_req_ack); end
        checks++; if (p1_resp !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL pend_p1_resp: got %0h expected 1", p1_resp); end
        step();
        mem_resp = SCR1_MEM_RESP_NOTRDY;
        #2;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pend_grant_req: got %0h expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_0140) begin errors++; $display("FAIL pend_grant_addr: got %0h expected 140", mem_addr); end
        checks++; if (p0_req_ack !== 1'b1) begin errors++; $display("FAIL pend_grant_ack: got %0h expected 1", p0_req_ack); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        p0_req = 1'b1; mem_req_ack = 1'b1;
        step();
        p0_req = 1'b0; mem_req_ack = 1'b0;
        #2;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %0h expected 1", arb_busy); end
        rst_n = 1'b0; p0_req = 1'b1; mem_req_ack = 1'b1;
        #1;
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rmid_rst_busy: got %0h expected 0", arb_busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_rst_req: got %0h expected 0", mem_req); end
        checks++; if (p0_req_ack !== 1'b0) begin errors++; $display("FAIL rmid_rst_ack: got %0h expected 0", p0_req_ack); end
        step();
        p0_req = 1'b0; mem_req_ack = 1'b0; rst_n = 1'b1;
        mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata[0] = 32'h0000_0055;
        #2;
        checks++; if (p0_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rmid_stray_resp: got %0h expected 0", p0_resp); end
        checks++; if (p0_rdata !== zero_vec) begin errors++; $display("FAIL rmid_stray_rdata: got %0h expected 0", p0_rdata); end
        step();
        mem_resp = SCR1_MEM_RESP_NOTRDY; p0_req = 1'b1; p0_addr = 32'h0000_0180; mem_req_ack = 1'b1;
        #2;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_new_req: got %0h expected 1", mem_req); end
        checks++; if (p0_req_ack !== 1'b1) begin errors++; $display("FAIL rmid_new_ack: got %0h expected 1", p0_req_ack); end
        checks++; if (mem_addr !== 32'h0000_0180) begin errors++; $display("FAIL rmid_new_addr: got %0h expected 180", mem_addr); end
        step();
        p0_req = 1'b0; mem_req_ack = 1'b0;
        #2;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL rmid_new_busy: got %0h expected 1", arb_busy); end
        idle_inputs();
    endtask

    task automatic test_resp_at_timeout();
        do_reset();
        p0_req = 1'b1; mem_req_ack = 1'b1;
        #2;
        checks++; if (p0_req_ack_4 !== 1'b1) begin errors++; $display("FAIL rt4_ack: got %0h expected 1", p0_req_ack_4); end
        step();
        p0_req = 1'b0; mem_req_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (p0_resp_4 !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rt4_wait[%0d]: got %0h expected 0", k, p0_resp_4); end
            step();
        end
        mem_resp = SCR1_MEM_RESP_RDY_ER; mem_rdata = '0; mem_rdata[0] = 32'h1234_5678;
        exp_vec = '0; exp_vec[0] = 32'h1234_5678;
        #2;
        checks++; if (p0_resp_4 !== SCR1_MEM_RESP_RDY_ER) begin errors++; $display("FAIL rt4_resp: got %0h expected 2", p0_resp_4); end
        checks++; if (p0_rdata_4 !== exp_vec) begin errors++; $display("FAIL rt4_rdata: got %0h expected %0h", p0_rdata_4, exp_vec); end
        step();
        mem_resp = SCR1_MEM_RESP_NOTRDY;
        #2;
        checks++; if (arb_busy_4 !== 1'b0) begin errors++; $display("FAIL rt4_idle: got %0h expected 0", arb_busy_4); end
        // Same sequence with no response at the deadline: local error then DRAIN.
        p0_req = 1'b1; mem_req_ack = 1'b1;
        step();
        p0_req = 1'b0; mem_req_ack = 1'b0;
        repeat (3) step();
        #2;
        checks++; if (p0_resp_4 !== SCR1_MEM_RESP_RDY_ER) begin errors++; $display("FAIL to4_resp: got %0h expected 2", p0_resp_4); end
        checks++; if (p0_rdata_4 !== zero_vec) begin errors++; $display("FAIL to4_rdata: got %0h expected 0", p0_rdata_4); end
        step();
        #2;
        checks++; if (arb_busy_4 !== 1'b1) begin errors++; $display("FAIL to4_drain: got %0h expected 1", arb_busy_4); end
        idle_inputs();
    endtask

    initial begin
        zero_vec = '0;
        exp_vec  = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_pending();
        test_reset_mid();
        test_resp_at_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rlwe_dmem_arb.md
RLWE_DMEM_ARB -- requirements
Module: rlwe_dmem_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, response timeout in clk cycles (range 2..255).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 p0_req / p0_cmd / p0_width / p0_addr / p0_wdata  in  1 / type_scr1_mem_cmd_e / type_scr1_mem_width_e / `SCR1_DMEM_AWIDTH / type_vector  port 0 (core LSU) request.
REQ-005 p0_req_ack  out  1; p0_rdata  out  type_vector; p0_resp  out  type_scr1_mem_resp_e  port 0 handshake and response.
REQ-006 p1_req / p1_cmd / p1_width / p1_addr / p1_wdata  in  same types as port 0  port 1 (RLWE vector engine) request.
REQ-007 p1_req_ack  out  1; p1_rdata  out  type_vector; p1_resp  out  type_scr1_mem_resp_e  port 1 handshake and response.
REQ-008 mem_req / mem_cmd / mem_width / mem_addr / mem_wdata  out  same types  shared DMEM request.
REQ-009 mem_req_ack  in  1; mem_rdata  in  type_vector; mem_resp  in  type_scr1_mem_resp_e  shared DMEM handshake and response.
REQ-010 arb_busy  out  1  high in any state other than IDLE.

Function
REQ-011 States: IDLE, BUSY, DRAIN. At most one DMEM transaction outstanding.
REQ-012 IDLE: one requester active -> that requester is granted; both active -> the port not in last_grant is granted (round-robin).
REQ-013 IDLE: mem_req equals the granted port's req; mem_cmd/width/addr/wdata come combinationally from the granted port. With no request: mem_req=0, other mem_* outputs come from port 0.
REQ-014 pX_req_ack = mem_req_ack & (grant==X) & (state==IDLE); the non-granted port's ack is 0.
REQ-015 IDLE with mem_req & mem_req_ack -> BUSY next cycle; owner<=grant, last_grant<=grant, timer<=0.
REQ-016 BUSY/DRAIN: mem_req=0 and both req_acks are 0; a request arriving in these states waits until IDLE.
REQ-017 BUSY: owner's resp=mem_resp and rdata=mem_rdata, combinationally, zero added latency; non-owner resp=SCR1_MEM_RESP_NOTRDY, rdata='0.
REQ-018 BUSY with mem_resp RDY_OK or RDY_ER -> IDLE next cycle. No new grant in the response cycle; the next request is issued the following cycle at the earliest.
REQ-019 BUSY: timer increments by 1 each cycle without a response and saturates at TIMEOUT_CYCLES.
REQ-020 BUSY, timer==TIMEOUT_CYCLES-1, no response: owner receives RDY_ER with rdata='0 for that one cycle; state -> DRAIN.
REQ-021 DRAIN: both ports see NOTRDY and rdata '0; the late mem_resp OK/ER is swallowed; state -> IDLE next cycle. DRAIN has no exit without a response.
REQ-022 IDLE: both ports see NOTRDY and rdata '0; any mem_resp seen in IDLE is ignored.
REQ-023 Response and timeout in the same cycle: the response wins; it is forwarded as in REQ-017 and state -> IDLE.

Reset
REQ-024 Async assert: state=IDLE, last_grant=port 1 (port 0 wins first contention), owner=port 0, timer=0.
REQ-025 Outputs while in reset: mem_req=0, p0/p1_req_ack=0, p0/p1_resp=NOTRDY, p0/p1_rdata='0, arb_busy=0.
REQ-026 Reset mid-transaction abandons it; any response arriving after reset release is ignored per REQ-022.

Structure
REQ-027 Package rlwe_arb_pkg holds the state enum (type_rlwe_arb_fsm_e), the port-id type, and the TIMEOUT_CYCLES default. Memory command/width/response types are the existing memif types.
REQ-028 Single module, no sub-modules. The timer is an 8-bit counter inline.

Verification
REQ-029 p0 LW addr 0x100 alone, ack cycle 0, RDY_OK cycle 2 with rdata[0]=0xDEADBEEF -> p0 receives it, p1_resp=NOTRDY, IDLE in cycle 3.
REQ-030 p0 and p1 request continuously from reset -> grants alternate p0,p1,p0,p1; each new mem_req starts one cycle after the previous response.
REQ-031 p1 SV granted, no response for 255 cycles -> p1_resp=RDY_ER at timer 254, then DRAIN; late RDY_OK not forwarded; then IDLE.
REQ-032 p0 pending while p1 BUSY -> p0_req_ack stays 0 and mem_req stays 0 until the cycle after p1's response.
REQ-033 rst_n low during BUSY, then released -> outputs at reset values, stray RDY_OK ignored, the next p0 request is granted normally.
REQ-034 Response and timeout in the same cycle (TIMEOUT_CYCLES=4, RDY_ER at timer 3) -> owner sees mem_resp and mem_rdata, state -> IDLE, not DRAIN.
